// File: rtl/sram_controller.sv
// sram_controller: synchronous initiator for a 62256-style 32 KiB asynchronous SRAM.
// Each request runs SETUP -> STROBE -> HOLD with programmable phase lengths.
// A single 4-bit down-counter times whichever phase is active.
// Read data is captured on the edge that ends the strobe phase.
module sram_controller #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [14:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic [14:0] sram_addr,
    inout  wire  [7:0]  sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    // Phase lengths must fit the 4-bit counter and be at least one cycle.
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
        STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_param_err
        $error("sram_controller: SETUP/STROBE/HOLD_CYCLES must each be in 1..15");
    end

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        drive_en;

    // Next-state logic: phase sequencing, request latch and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    // OE has been low for the full strobe; the SRAM output is settled.
                    if (!we_q) begin
                        rdata_d = sram_data;
                    end
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 15'd0;
            wdata_q <= 8'd0;
            we_q    <= 1'b0;
            rdata_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Strobes decode straight from registered state, so they are glitch-free
    // relative to the clock and OE/WE can never overlap.
    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = (state_q == IDLE);
    assign sram_oe_n = !((state_q == STROBE) && !we_q);
    assign sram_we_n = !((state_q == STROBE) && we_q);
    assign drive_en  = (state_q != IDLE) && we_q;

    // Per-bit tristate driver: bus is released whenever no write is in flight.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bus
        assign sram_data[gi] = drive_en ? wdata_q[gi] : 1'bz;
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench for sram_controller.
// Instance 0 uses default timing, instance 1 a 5-cycle strobe.
// Each instance has a 62256 behavioural model; the bus has pull-ups so a
// released bus reads 8'hFF.
module tb_sram_controller;

    typedef struct {
        int          inst;
        bit          w;
        logic [14:0] a;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          gap;
    } exp_t;

    localparam logic [7:0] BUS_FREE = 8'hFF;

    logic        clk;
    int          cyc;
    int          n_pass;
    int          n_total;
    exp_t        exp_q[$];

    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [1:0]  rstn_v;
    logic [14:0] addr_a [2];
    logic [7:0]  wdata_a [2];
    wire  [1:0]  ready_v;
    wire  [1:0]  done_v;
    wire  [1:0]  ce_n_v;
    wire  [1:0]  oe_n_v;
    wire  [1:0]  we_n_v;
    wire  [15:0] rdata_p;
    wire  [15:0] bus_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int S  = (gi == 0) ? 2 : 5;
        localparam int CE = S + 2;

        wire  [7:0]  bus;
        wire  [14:0] sram_addr;
        wire  [7:0]  rdata;
        wire         ce_n, oe_n, wr_n, ready, done;
        logic [7:0]  mem [32768];

        sram_controller #(
            .SETUP_CYCLES (1),
            .STROBE_CYCLES(S),
            .HOLD_CYCLES  (1)
        ) u_dut (
            .clock    (clk),
            .reset_n  (rstn_v[gi]),
            .req      (req_v[gi]),
            .ready    (ready),
            .we       (we_v[gi]),
            .addr     (addr_a[gi]),
            .wdata    (wdata_a[gi]),
            .rdata    (rdata),
            .done     (done),
            .sram_addr(sram_addr),
            .sram_data(bus),
            .sram_ce_n(ce_n),
            .sram_oe_n(oe_n),
            .sram_we_n(wr_n)
        );

        for (genvar bi = 0; bi < 8; bi++) begin : g_pu
            pullup (bus[bi]);
        end

        // 62256 model: drives on CE+OE with WE high, stores while CE+WE low.
        assign bus = (!ce_n && !oe_n && wr_n) ? mem[sram_addr] : 8'hzz;
        always @(posedge clk) if (!ce_n && !wr_n) mem[sram_addr] <= bus;

        assign ready_v[gi]            = ready;
        assign done_v[gi]             = done;
        assign ce_n_v[gi]             = ce_n;
        assign oe_n_v[gi]             = oe_n;
        assign we_n_v[gi]             = wr_n;
        assign rdata_p[gi*8 +: 8]     = rdata;
        assign bus_p[gi*8 +: 8]       = bus;

        int          acc_edge, ce_cnt, we_cnt, oe_cnt, bus_cnt, viol, hi_run, gap;
        bit          cur_we, prev_done;
        logic [14:0] cur_a;
        logic [7:0]  cur_wd;
        exp_t        e;

        // Monitor: accumulates per-transaction strobe statistics and scores on done.
        always @(negedge clk) begin
            if (!rstn_v[gi]) begin
                hi_run    = 0;
                prev_done = 1'b0;
            end else begin
                if (done && prev_done) chk($sformatf("done_pulse%0d", gi), 1, 0);
                if (done) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != gi) begin
                        chk($sformatf("unexpected_done%0d", gi), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("latency%0d@%0h", gi, e.a), cyc - acc_edge, CE);
                        chk($sformatf("ce_low%0d@%0h", gi, e.a), ce_cnt, CE);
                        chk($sformatf("we_low%0d@%0h", gi, e.a), we_cnt, e.w ? S : 0);
                        chk($sformatf("oe_low%0d@%0h", gi, e.a), oe_cnt, e.w ? 0 : S);
                        chk($sformatf("bus%0d@%0h", gi, e.a), bus_cnt, e.w ? CE : 2);
                        chk($sformatf("invariant%0d@%0h", gi, e.a), viol, 0);
                        chk($sformatf("rdata%0d@%0h", gi, e.a), int'(rdata), int'(e.rd));
                        if (e.w) chk($sformatf("mem%0d@%0h", gi, e.a), int'(mem[e.a]), int'(e.wd));
                        if (e.gap >= 0) chk($sformatf("gap%0d@%0h", gi, e.a), gap, e.gap);
                    end
                end
                if (ready && req_v[gi]) begin
                    acc_edge = cyc + 1;
                    cur_we   = we_v[gi];
                    cur_a    = addr_a[gi];
                    cur_wd   = wdata_a[gi];
                    ce_cnt   = 0; we_cnt = 0; oe_cnt = 0; bus_cnt = 0; viol = 0;
                    gap      = -1;
                end else if (!ce_n) begin
                    if (gap < 0) begin
                        gap    = hi_run;
                        hi_run = 0;
                    end
                    ce_cnt++;
                    if (!wr_n) we_cnt++;
                    if (!oe_n) oe_cnt++;
                    if (cur_we && bus == cur_wd) bus_cnt++;
                    if (!cur_we && oe_n && bus == BUS_FREE) bus_cnt++;
                    if (!oe_n && !wr_n) viol++;
                    if (!oe_n && cur_we) viol++;
                    if (sram_addr != cur_a) viol++;
                end
                if (ce_n) hi_run++;
                prev_done = done;
            end
        end
    end

    task automatic issue(input int k, input bit w, input logic [14:0] a,
                         input logic [7:0] wd, input logic [7:0] rd, input int gap);
        exp_t x;
        int n = 0;
        while (!ready_v[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        req_v[k]   = 1'b1;
        we_v[k]    = w;
        addr_a[k]  = a;
        wdata_a[k] = wd;
        x.inst = k; x.w = w; x.a = a; x.wd = wd; x.rd = rd; x.gap = gap;
        exp_q.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (!done_v[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_low(input int k, input bit want_we);
        int n = 0;
        while ((want_we ? we_n_v[k] : oe_n_v[k]) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("strobe_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0;
        req_v = 2'b11; we_v = 2'b00; rstn_v = 2'b00;
        addr_a[0] = 15'h0; addr_a[1] = 15'h0;
        wdata_a[0] = 8'h0; wdata_a[1] = 8'h0;

        // Reset with req asserted: nothing may start.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), ready_v[k], 1);
            chk($sformatf("rst_done%0d", k), done_v[k], 0);
            chk($sformatf("rst_rdata%0d", k), int'(rdata_p[k*8 +: 8]), 0);
            chk($sformatf("rst_ce%0d", k), ce_n_v[k], 1);
            chk($sformatf("rst_oe%0d", k), oe_n_v[k], 1);
            chk($sformatf("rst_we%0d", k), we_n_v[k], 1);
            chk($sformatf("rst_bus%0d", k), int'(bus_p[k*8 +: 8]), int'(BUS_FREE));
        end
        req_v = 2'b00;
        rstn_v = 2'b11;
        @(posedge clk); #1;
        chk("rst_no_txn", ce_n_v[0], 1);

        // Write then readback, then a write that must not disturb rdata.
        issue(0, 1'b1, 15'h1234, 8'hA5, 8'h00, -1); req_v[0] = 1'b0; wait_done(0);
        issue(0, 1'b0, 15'h1234, 8'h00, 8'hA5, -1); req_v[0] = 1'b0; wait_done(0);
        issue(0, 1'b1, 15'h0001, 8'h11, 8'hA5, -1); req_v[0] = 1'b0; wait_done(0);

        // Back-to-back with req held: top and bottom of the address space.
        issue(0, 1'b1, 15'h7FFF, 8'h3C, 8'hA5, -1);
        issue(0, 1'b0, 15'h7FFF, 8'h00, 8'h3C, 1);
        req_v[0] = 1'b0; wait_done(0);
        issue(0, 1'b1, 15'h0000, 8'hC3, 8'h3C, -1);
        issue(0, 1'b0, 15'h0000, 8'h00, 8'hC3, 1);
        req_v[0] = 1'b0; wait_done(0);

        // Long strobe: req pulse and input changes while busy are ignored.
        issue(1, 1'b1, 15'h0100, 8'h5A, 8'h00, -1); req_v[1] = 1'b0; wait_done(1);
        issue(1, 1'b0, 15'h0100, 8'h00, 8'h5A, -1); req_v[1] = 1'b0;
        wait_low(1, 1'b0);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_a[1] = 15'h0555; wdata_a[1] = 8'hEE;
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        wait_done(1);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_no_extra", ce_n_v[1], 1);

        // Reset in the middle of a write strobe aborts without done.
        issue(1, 1'b1, 15'h0200, 8'h77, 8'h5A, -1); req_v[1] = 1'b0;
        wait_low(1, 1'b1);
        rstn_v[1] = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        chk("abort_we", we_n_v[1], 1);
        chk("abort_ce", ce_n_v[1], 1);
        chk("abort_oe", oe_n_v[1], 1);
        chk("abort_bus", int'(bus_p[15:8]), int'(BUS_FREE));
        chk("abort_ready", ready_v[1], 1);
        chk("abort_done", done_v[1], 0);
        rstn_v[1] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_rdata", int'(rdata_p[15:8]), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
